// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the two-way intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter: cleared on load, counts up otherwise, flags the last cycle of a phase.
module phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] last_count;

  assign last_count = value - ONE;
  assign done       = (count_reg == last_count);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + ONE;
    end
  end

endmodule

// File: rtl/traffic_light_controller.sv
// Fixed-time NS/EW intersection controller: Moore FSM stepped by phase_timer,
// lamps decoded combinationally from the registered state.
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES   = 5,
  parameter int YELLOW_CYCLES  = 2,
  parameter int ALL_RED_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] NS,
  output logic [2:0] EW
);

  localparam int MAX_CYCLES = max3(GREEN_CYCLES, YELLOW_CYCLES, ALL_RED_CYCLES);
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  state_t          state_reg;
  logic [CW-1:0]   duration;
  logic            legal;
  logic            done;
  logic            load;

  always_comb begin
    duration = CW'(ALL_RED_CYCLES);
    legal    = 1'b1;
    case (state_reg)
      NS_GREEN, EW_GREEN:   duration = CW'(GREEN_CYCLES);
      NS_YELLOW, EW_YELLOW: duration = CW'(YELLOW_CYCLES);
      ALL_RED_A, ALL_RED_B: duration = CW'(ALL_RED_CYCLES);
      default:              legal    = 1'b0;
    endcase
  end

  // An illegal encoding forces a state change so recovery never waits on the counter.
  assign load = done | ~legal;

  phase_timer #(
    .WIDTH (CW)
  ) u_phase_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (duration),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= NS_GREEN;
    end else if (load) begin
      case (state_reg)
        NS_GREEN:  state_reg <= NS_YELLOW;
        NS_YELLOW: state_reg <= ALL_RED_A;
        ALL_RED_A: state_reg <= EW_GREEN;
        EW_GREEN:  state_reg <= EW_YELLOW;
        EW_YELLOW: state_reg <= ALL_RED_B;
        ALL_RED_B: state_reg <= NS_GREEN;
        default:   state_reg <= ALL_RED_B;
      endcase
    end
  end

  // Default is all-red so any unexpected encoding fails safe.
  always_comb begin
    NS = LAMP_RED;
    EW = LAMP_RED;
    case (state_reg)
      NS_GREEN:  NS = LAMP_GREEN;
      NS_YELLOW: NS = LAMP_YELLOW;
      EW_GREEN:  EW = LAMP_GREEN;
      EW_YELLOW: EW = LAMP_YELLOW;
      default: begin
        NS = LAMP_RED;
        EW = LAMP_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: default and overridden instances checked
// every cycle against a phase-position model, plus directed literal checks.
module tb_traffic_light_controller;

  localparam int G1 = 5, Y1 = 2, A1 = 1, P1 = 2 * (G1 + Y1 + A1);
  localparam int G2 = 3, Y2 = 1, A2 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] ns1, ew1, ns2, ew2;

  int errors = 0;
  int checks = 0;
  int t1 = 0;
  int t2 = 0;
  bit valid = 1'b0;
  bit forced_now = 1'b0;

  always #5 clk = ~clk;

  traffic_light_controller dut (
    .clk (clk),
    .rst (rst),
    .NS  (ns1),
    .EW  (ew1)
  );

  traffic_light_controller #(
    .GREEN_CYCLES   (G2),
    .YELLOW_CYCLES  (Y2),
    .ALL_RED_CYCLES (A2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .NS  (ns2),
    .EW  (ew2)
  );

  // Expected {NS,EW} from the position t within the repeating phase schedule.
  function automatic logic [5:0] model_lamps(input int t, input int g, input int y, input int a);
    int m;
    m = t % (2 * (g + y + a));
    if (m < g)                 return {3'b001, 3'b100};
    if (m < g + y)             return {3'b010, 3'b100};
    if (m < g + y + a)         return {3'b100, 3'b100};
    if (m < 2 * g + y + a)     return {3'b100, 3'b001};
    if (m < 2 * g + 2 * y + a) return {3'b100, 3'b010};
    return {3'b100, 3'b100};
  endfunction

  function automatic logic safe(input logic [2:0] ns, input logic [2:0] ew);
    return $onehot(ns) && $onehot(ew) && (ns[2] || ew[2]) &&
           !((ns[0] | ns[1]) && (ew[0] | ew[1]));
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  // Model time advances on every edge; reset rewinds it, a forced illegal state jumps to ALL_RED_B.
  always @(posedge clk) begin
    if (!rst) begin
      t1    <= 0;
      t2    <= 0;
      valid <= 1'b1;
    end else begin
      t1 <= forced_now ? (P1 - A1) : (t1 + 1);
      t2 <= t2 + 1;
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      check("dut_lamps", {ns1, ew1}, forced_now ? 6'b100100 : model_lamps(t1, G1, Y1, A1));
      check("dut2_lamps", {ns2, ew2}, model_lamps(t2, G2, Y2, A2));
      check("dut_safety", {5'b0, safe(ns1, ew1)}, 6'd1);
      check("dut2_safety", {5'b0, safe(ns2, ew2)}, 6'd1);
    end
  end

  initial begin
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", {ns1, ew1}, 6'b001100);
      check("reset_hold2", {ns2, ew2}, 6'b001100);
    end
    rst = 1'b1;
    $display("reset released, running 3 default periods");

    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (k % 16 < 5)   check("ns_green", {ns1, ew1}, 6'b001100);
      if (k % 16 == 5)  check("ns_yellow_start", {ns1, ew1}, 6'b010100);
      if (k % 16 == 7)  check("all_red_a", {ns1, ew1}, 6'b100100);
      if (k % 16 == 8)  check("ew_green_start", {ns1, ew1}, 6'b100001);
      if (k % 16 == 13) check("ew_yellow_start", {ns1, ew1}, 6'b100010);
      if (k % 16 == 15) check("all_red_b", {ns1, ew1}, 6'b100100);
      if (k % 12 == 3)  check("ovr_ns_yellow", {ns2, ew2}, 6'b010100);
      if (k % 12 == 4)  check("ovr_all_red_a", {ns2, ew2}, 6'b100100);
      if (k % 12 == 6)  check("ovr_ew_green", {ns2, ew2}, 6'b100001);
      if (k % 12 == 9)  check("ovr_ew_yellow", {ns2, ew2}, 6'b100010);
      if (k % 12 == 11) check("ovr_all_red_b", {ns2, ew2}, 6'b100100);
      if (k % 16 == 0)  $display("default period ending at cycle %0d", k);
    end

    repeat (9) @(negedge clk);
    check("ew_green_cycle2", {ns1, ew1}, 6'b100001);
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset", {ns1, ew1}, 6'b001100);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("post_reset_green", {ns1, ew1}, 6'b001100);
    end
    @(negedge clk);
    check("post_reset_yellow", {ns1, ew1}, 6'b010100);
    $display("mid-phase reset sequence done");

    @(posedge clk);
    #1;
    force dut.state_reg = traffic_pkg::state_t'(3'd7);
    forced_now = 1'b1;
    @(negedge clk);
    check("illegal_decode", {ns1, ew1}, 6'b100100);
    #1;
    release dut.state_reg;
    @(posedge clk);
    #1;
    forced_now = 1'b0;
    @(negedge clk);
    check("illegal_to_all_red_b", {ns1, ew1}, 6'b100100);
    @(negedge clk);
    check("illegal_recovered", {ns1, ew1}, 6'b001100);
    $display("illegal state recovery done");

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 15) != 0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    $display("random reset run done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
